dual_rail_wavefront_driver: RTL

Clocked bridge between synchronous logic and the dual-rail adder/overflow datapath. It accepts single-rail operand pairs, launches a DATA wavefront into the adder, and waits for dual-rail completion of the sum word plus the overflow rail. It then returns the datapath to NULL, waits for the NULL wavefront, and hands back a single-rail sum, overflow flag and error flag. It is the sequencer that sits upstream of the adder and downstream of the overflow detector's OF_t/OF_f pair.

---
 rtl/dual_rail_pkg.sv | 16 +
 rtl/dual_rail_completion.sv | 24 ++
 rtl/dual_rail_wavefront_driver.sv | 121 ++++++++++++
 3 files changed

// File: rtl/dual_rail_pkg.sv
// dual_rail_pkg: sequencer states and per-pair dual-rail code helpers.
package dual_rail_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_DATA, WAIT_NULL, RESULT} state_t;
    function automatic logic [1:0] dr_encode(input logic b);
        return {b, ~b};
    endfunction
    function automatic logic dr_is_data(input logic t, input logic f);
        return t ^ f;
    endfunction
    function automatic logic dr_is_null(input logic t, input logic f);
        return ~(t | f);
    endfunction
    function automatic logic dr_is_illegal(input logic t, input logic f);
        return t & f;
    endfunction
endpackage

// File: rtl/dual_rail_completion.sv
// dual_rail_completion: combinational DATA/NULL/ILLEGAL detection over N dual-rail pairs.
module dual_rail_completion
    import dual_rail_pkg::*;
#(
    parameter int N = 9
) (
    input  logic [N-1:0] t,
    input  logic [N-1:0] f,
    output logic         complete,
    output logic         all_null,
    output logic         illegal
);
    logic [N-1:0] is_data;
    logic [N-1:0] is_null;
    logic [N-1:0] is_bad;
    for (genvar g = 0; g < N; g++) begin : g_pair
        assign is_data[g] = dr_is_data(t[g], f[g]);
        assign is_null[g] = dr_is_null(t[g], f[g]);
        assign is_bad[g]  = dr_is_illegal(t[g], f[g]);
    end
    assign complete = &is_data;
    assign all_null = &is_null;
    assign illegal  = |is_bad;
endmodule

// File: rtl/dual_rail_wavefront_driver.sv
// dual_rail_wavefront_driver: launches DATA/NULL wavefronts into a dual-rail adder
// and returns a registered single-rail sum, overflow and error flag.
module dual_rail_wavefront_driver
    import dual_rail_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] a_t,
    output logic [WIDTH-1:0] a_f,
    output logic [WIDTH-1:0] b_t,
    output logic [WIDTH-1:0] b_f,
    input  logic [WIDTH-1:0] s_t,
    input  logic [WIDTH-1:0] s_f,
    input  logic             of_t,
    input  logic             of_f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_of,
    output logic             out_err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t        state;
    logic [1:0]    stab;
    logic [CW-1:0] wait_cnt;
    logic          complete;
    logic          all_null;
    logic          illegal;
    logic          timed_out;
    dual_rail_completion #(.N(WIDTH + 1)) u_completion (
        .t        ({of_t, s_t}),
        .f        ({of_f, s_f}),
        .complete (complete),
        .all_null (all_null),
        .illegal  (illegal)
    );
    // wait_cnt holds edges already spent, so this edge is the TIMEOUT-th one
    assign timed_out = wait_cnt == CW'(TIMEOUT - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            stab      <= '0;
            wait_cnt  <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_of    <= 1'b0;
            out_err   <= 1'b0;
            a_t       <= '0;
            a_f       <= '0;
            b_t       <= '0;
            b_f       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        a_t      <= in_a;
                        a_f      <= ~in_a;
                        b_t      <= in_b;
                        b_f      <= ~in_b;
                        in_ready <= 1'b0;
                        out_sum  <= '0;
                        out_of   <= 1'b0;
                        out_err  <= 1'b0;
                        stab     <= '0;
                        wait_cnt <= '0;
                        state    <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    stab     <= complete ? stab + 2'd1 : 2'd0;
                    if (illegal) out_err <= 1'b1;
                    if ((complete && stab == 2'd1) || timed_out) begin
                        if (complete && stab == 2'd1) begin
                            out_sum <= s_t;
                            out_of  <= of_t;
                        end else begin
                            out_err <= 1'b1;
                        end
                        a_t      <= '0;
                        a_f      <= '0;
                        b_t      <= '0;
                        b_f      <= '0;
                        stab     <= '0;
                        wait_cnt <= '0;
                        state    <= WAIT_NULL;
                    end
                end
                WAIT_NULL: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    stab     <= all_null ? stab + 2'd1 : 2'd0;
                    if (illegal) out_err <= 1'b1;
                    if ((all_null && stab == 2'd1) || timed_out) begin
                        if (!(all_null && stab == 2'd1)) out_err <= 1'b1;
                        stab      <= '0;
                        wait_cnt  <= '0;
                        out_valid <= 1'b1;
                        state     <= RESULT;
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
